ic_number_entry: RTL and testbench
==================================

Name: ic_number_entry

Overview:
- Operator-entry front end for the IC tester: collects decimal digits from the debounced keypad stage and accumulates them into a binary IC part number (e.g. 7408).
- On Enter, latches the number and issues a start strobe to the downstream decode/test stage.
- Drives the icNumber input of the decode/test logic; exposes BCD digits for the display driver.

Parameters:
- MAX_DIGITS, 5, maximum digits accepted (legal range 1..9, keeps accumulator within 32 bits)
- KEY_CLEAR, 4'hC, key code that clears entry
- KEY_ENTER, 4'hE, key code that commits entry

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- key_valid  input  1  one-cycle strobe, key_code valid
- key_code  input  4  0-9 digit, KEY_CLEAR, KEY_ENTER, others ignored
- tester_busy  input  1  high while downstream test sequence runs
- ic_number  output  32  committed IC number (binary)
- number_valid  output  1  high while ic_number holds a committed value
- start  output  1  one-cycle test start strobe
- digit_count  output  4  digits currently entered
- disp_bcd  output  4*MAX_DIGITS  entered digits, newest in low nibble
- overflow_err  output  1  one-cycle pulse, digit rejected (entry full)

Behaviour:
- Reset (sync, rst=1 at edge): state EMPTY; acc, ic_number, disp_bcd, digit_count = 0; number_valid, start, overflow_err = 0. rst wins over any simultaneous key.
- Keys are sampled only on edges where key_valid=1; each such cycle is one keypress (no internal debounce). All updates take effect at that edge; start/overflow_err are high the cycle immediately after the sampling edge, for exactly one cycle.
- Codes other than 0-9, KEY_CLEAR, KEY_ENTER: ignored in all states.
- Accumulate: acc_next = acc*10 + digit, computed as (acc<<3)+(acc<<1)+digit, 32-bit, no truncation for MAX_DIGITS<=9. disp_bcd shifts left 4, digit into low nibble; digit_count++.
- State EMPTY (count=0):
  - digit: acc=digit, disp_bcd={0..,digit}, count=1, go ENTRY.
  - Enter, Clear: no effect.
- State ENTRY:
  - digit with count<MAX_DIGITS: accumulate.
  - digit with count==MAX_DIGITS: ignored, overflow_err pulse, acc/disp unchanged.
  - Enter with tester_busy=0: ic_number=acc, number_valid=1, start pulse, go LOCKED.
  - Enter with tester_busy=1: ignored, remain ENTRY, no start.
  - Clear: acc, disp_bcd, count = 0, go EMPTY.
- State LOCKED:
  - digits: ignored (no overflow_err).
  - Enter with tester_busy=0: re-issue start pulse (retest same part), ic_number unchanged.
  - Enter with tester_busy=1: ignored.
  - Clear: acc, disp_bcd, count, ic_number = 0; number_valid=0; go EMPTY.
- ic_number changes only on a committing Enter or on Clear from LOCKED; stable otherwise, including while tester_busy.
- Leading zeros count as digits (entering 0,7,4,0,8 gives count=5, ic_number=7408).
- start never asserts on two consecutive cycles: key_valid back-to-back Enters yield one pulse per accepted Enter, separated by the strobe spacing.

Test Plan:
- Reset, keys 7,4,0,8 then Enter (busy=0) -> ic_number=7408, number_valid=1, start high exactly 1 cycle after Enter edge, disp_bcd=20'h07408, digit_count=4.
- Keys 7,4,1,2,5,1 (MAX_DIGITS=5) -> sixth digit rejected, overflow_err single pulse, Enter gives ic_number=74125, disp_bcd=20'h74125.
- Keys 7,4,0,0, Enter with tester_busy=1 -> no start, number_valid=0, stays ENTRY; drop busy, Enter -> start pulse, ic_number=7400.
- In LOCKED with 7408: digit 3 ignored; Enter (busy=0) -> second start pulse, ic_number still 7408; Clear -> number_valid=0, ic_number=0, disp_bcd=0.
- Enter and Clear in EMPTY after reset -> no start, all outputs remain 0; unknown code 4'hA in ENTRY -> no change.
- Keys 7,4 then rst=1 asserted in same cycle as key_valid with digit 0 -> all outputs 0, state EMPTY; subsequent 3,2, Enter -> ic_number=32.

Source files
------------

// File: rtl/ic_number_entry.sv
// ic_number_entry
// Operator-entry front end for the IC tester. Decimal digits from the
// debounced keypad are accumulated into a binary part number (e.g. 7408).
// Enter latches the number and issues a one-cycle start strobe to the
// downstream decode/test stage; Clear abandons the entry.
//
// State table
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_EMPTY   | no digits entered, waiting for the first digit
//   ST_ENTRY   | one or more digits entered, number not yet committed
//   ST_LOCKED  | number committed to ic_number; Enter re-issues start
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous reset, active-high
//   key_valid     in   one-cycle strobe, key_code valid
//   key_code      in   [3:0] 0-9 digit, KEY_CLEAR, KEY_ENTER, others ignored
//   tester_busy   in   high while the downstream test sequence runs
//   ic_number     out  [31:0] committed IC number (binary)
//   number_valid  out  high while ic_number holds a committed value
//   start         out  one-cycle test start strobe
//   digit_count   out  [3:0] digits currently entered
//   disp_bcd      out  [4*MAX_DIGITS-1:0] entered digits, newest in low nibble
//   overflow_err  out  one-cycle pulse, digit rejected because entry is full

module ic_number_entry #(
    parameter int         MAX_DIGITS = 5,
    parameter logic [3:0] KEY_CLEAR  = 4'hC,
    parameter logic [3:0] KEY_ENTER  = 4'hE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    input  logic                    tester_busy,
    output logic [31:0]             ic_number,
    output logic                    number_valid,
    output logic                    start,
    output logic [3:0]              digit_count,
    output logic [4*MAX_DIGITS-1:0] disp_bcd,
    output logic                    overflow_err
);

    localparam int         DISP_W  = 4 * MAX_DIGITS;
    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [31:0]         acc, acc_n;
    logic [31:0]         ic_n;
    logic                nv_n;
    logic                start_n;
    logic                ovf_n;
    logic [3:0]          cnt_n;
    logic [DISP_W-1:0]   disp_n;

    logic                is_digit;
    logic                is_enter;
    logic                is_clear;
    logic [31:0]         acc_mul10;
    logic [DISP_W-1:0]   disp_shift;

    assign is_digit = (key_code <= 4'd9);
    assign is_enter = (key_code == KEY_ENTER);
    assign is_clear = (key_code == KEY_CLEAR);

    // acc*10 + digit without a multiplier; MAX_DIGITS <= 9 keeps this in 32 bits.
    assign acc_mul10  = (acc << 3) + (acc << 1) + {28'd0, key_code};
    assign disp_shift = (disp_bcd << 4) | DISP_W'(key_code);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_EMPTY;
            acc          <= '0;
            ic_number    <= '0;
            number_valid <= 1'b0;
            start        <= 1'b0;
            overflow_err <= 1'b0;
            digit_count  <= '0;
            disp_bcd     <= '0;
        end else begin
            state        <= state_n;
            acc          <= acc_n;
            ic_number    <= ic_n;
            number_valid <= nv_n;
            start        <= start_n;
            overflow_err <= ovf_n;
            digit_count  <= cnt_n;
            disp_bcd     <= disp_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        ic_n    = ic_number;
        nv_n    = number_valid;
        start_n = 1'b0;
        ovf_n   = 1'b0;
        cnt_n   = digit_count;
        disp_n  = disp_bcd;

        if (key_valid) begin
            case (state)
                ST_EMPTY: begin
                    if (is_digit) begin
                        acc_n   = {28'd0, key_code};
                        disp_n  = DISP_W'(key_code);
                        cnt_n   = 4'd1;
                        state_n = ST_ENTRY;
                    end
                end

                ST_ENTRY: begin
                    if (is_digit) begin
                        if (digit_count < MAX_CNT) begin
                            acc_n  = acc_mul10;
                            disp_n = disp_shift;
                            cnt_n  = digit_count + 4'd1;
                        end else begin
                            ovf_n = 1'b1;
                        end
                    end else if (is_enter) begin
                        if (!tester_busy) begin
                            ic_n    = acc;
                            nv_n    = 1'b1;
                            start_n = 1'b1;
                            state_n = ST_LOCKED;
                        end
                    end else if (is_clear) begin
                        acc_n   = '0;
                        disp_n  = '0;
                        cnt_n   = '0;
                        state_n = ST_EMPTY;
                    end
                end

                ST_LOCKED: begin
                    // An Enter landing while start is still high is dropped so
                    // start can never be high on two consecutive cycles.
                    if (is_enter) begin
                        if (!tester_busy && !start) begin
                            start_n = 1'b1;
                        end
                    end else if (is_clear) begin
                        acc_n   = '0;
                        disp_n  = '0;
                        cnt_n   = '0;
                        ic_n    = '0;
                        nv_n    = 1'b0;
                        state_n = ST_EMPTY;
                    end
                end

                default: begin
                    state_n = ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ic_number_entry.sv
// Bench for ic_number_entry: directed vector table, a hand-written sequence,
// then randomized keypresses compared against a digit-list reference model.

module tb_ic_number_entry;

    localparam int         MAXD = 5;
    localparam logic [3:0] KC   = 4'hC;
    localparam logic [3:0] KE   = 4'hE;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_valid;
    logic [3:0]    key_code;
    logic          tester_busy;
    logic [31:0]   ic_number;
    logic          number_valid;
    logic          start;
    logic [3:0]    digit_count;
    logic [19:0]   disp_bcd;
    logic          overflow_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ic_number_entry #(.MAX_DIGITS(MAXD), .KEY_CLEAR(KC), .KEY_ENTER(KE)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .tester_busy  (tester_busy),
        .ic_number    (ic_number),
        .number_valid (number_valid),
        .start        (start),
        .digit_count  (digit_count),
        .disp_bcd     (disp_bcd),
        .overflow_err (overflow_err)
    );

    typedef struct {
        logic        rst;
        logic        kv;
        logic [3:0]  code;
        logic        busy;
        logic [31:0] ic;
        logic        nv;
        logic        st;
        logic [3:0]  cnt;
        logic [19:0] disp;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic kv, logic [3:0] code, logic busy,
                                logic [31:0] ic, logic nv, logic st,
                                logic [3:0] cnt, logic [19:0] disp, logic ovf);
        vec_t v;
        v.rst = r; v.kv = kv; v.code = code; v.busy = busy;
        v.ic = ic; v.nv = nv; v.st = st; v.cnt = cnt; v.disp = disp; v.ovf = ovf;
        vecs.push_back(v);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic [31:0] ic, logic nv, logic st,
                           logic [3:0] cnt, logic [19:0] disp, logic ovf);
        chk({tag, " ic_number"},    ic_number,            ic);
        chk({tag, " number_valid"}, {31'd0, number_valid}, {31'd0, nv});
        chk({tag, " start"},        {31'd0, start},        {31'd0, st});
        chk({tag, " digit_count"},  {28'd0, digit_count},  {28'd0, cnt});
        chk({tag, " disp_bcd"},     {12'd0, disp_bcd},     {12'd0, disp});
        chk({tag, " overflow_err"}, {31'd0, overflow_err}, {31'd0, ovf});
    endtask

    task automatic drive(logic r, logic kv, logic [3:0] code, logic busy);
        rst = r; key_valid = kv; key_code = code; tester_busy = busy;
        @(posedge clk);
        #1;
    endtask

    // Reference model: the entry is a list of digits plus a committed flag.
    int          m_q[$];
    bit          m_locked;
    logic [31:0] m_ic;
    bit          m_start;
    bit          m_ovf;

    function automatic void model_step(logic r, logic kv, logic [3:0] code, logic busy);
        bit prev_start = m_start;
        longint val;
        m_start = 0;
        m_ovf   = 0;
        if (r) begin
            m_q.delete();
            m_locked = 0;
            m_ic     = 0;
        end else if (kv) begin
            if (code <= 4'd9) begin
                if (!m_locked) begin
                    if (m_q.size() < MAXD) m_q.push_back(int'(code));
                    else                   m_ovf = 1;
                end
            end else if (code == KC) begin
                m_q.delete();
                if (m_locked) begin
                    m_locked = 0;
                    m_ic     = 0;
                end
            end else if (code == KE) begin
                if (m_q.size() > 0 && !busy && !(m_locked && prev_start)) begin
                    val = 0;
                    foreach (m_q[k]) val = val * 10 + m_q[k];
                    m_ic     = 32'(val);
                    m_locked = 1;
                    m_start  = 1;
                end
            end
        end
    endfunction

    function automatic logic [19:0] model_disp();
        logic [19:0] d = '0;
        foreach (m_q[k]) d = (d << 4) | 20'(m_q[k]);
        return d;
    endfunction

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; tester_busy = 1'b0;

        // rst kv code busy | ic nv st cnt disp ovf
        add(1,0,4'h0,0, 0,0,0,0,20'h0,0);
        add(0,1,KE  ,0, 0,0,0,0,20'h0,0);     // Enter in EMPTY
        add(0,1,KC  ,0, 0,0,0,0,20'h0,0);     // Clear in EMPTY
        add(0,1,4'h7,0, 0,0,0,1,20'h7,0);
        add(0,1,4'h4,0, 0,0,0,2,20'h74,0);
        add(0,1,4'hA,0, 0,0,0,2,20'h74,0);    // unknown code ignored
        add(0,1,4'h0,0, 0,0,0,3,20'h740,0);
        add(0,1,4'h8,0, 0,0,0,4,20'h7408,0);
        add(0,1,KE  ,0, 7408,1,1,4,20'h7408,0);
        add(0,0,4'h0,0, 7408,1,0,4,20'h7408,0);
        add(0,1,4'h3,0, 7408,1,0,4,20'h7408,0); // digit ignored in LOCKED
        add(0,1,KE  ,0, 7408,1,1,4,20'h7408,0); // retest
        add(0,1,KE  ,0, 7408,1,0,4,20'h7408,0); // back-to-back Enter dropped
        add(0,1,KE  ,1, 7408,1,0,4,20'h7408,0); // busy
        add(0,1,KC  ,0, 0,0,0,0,20'h0,0);
        add(0,1,4'h7,0, 0,0,0,1,20'h7,0);
        add(0,1,4'h4,0, 0,0,0,2,20'h74,0);
        add(0,1,4'h1,0, 0,0,0,3,20'h741,0);
        add(0,1,4'h2,0, 0,0,0,4,20'h7412,0);
        add(0,1,4'h5,0, 0,0,0,5,20'h74125,0);
        add(0,1,4'h1,0, 0,0,0,5,20'h74125,1); // sixth digit rejected
        add(0,0,4'h0,0, 0,0,0,5,20'h74125,0);
        add(0,1,KE  ,0, 74125,1,1,5,20'h74125,0);
        add(0,1,KC  ,0, 0,0,0,0,20'h0,0);
        add(0,1,4'h7,0, 0,0,0,1,20'h7,0);
        add(0,1,4'h4,0, 0,0,0,2,20'h74,0);
        add(0,1,4'h0,0, 0,0,0,3,20'h740,0);
        add(0,1,4'h0,0, 0,0,0,4,20'h7400,0);
        add(0,1,KE  ,1, 0,0,0,4,20'h7400,0);  // busy: stays ENTRY
        add(0,0,4'h0,0, 0,0,0,4,20'h7400,0);
        add(0,1,KE  ,0, 7400,1,1,4,20'h7400,0);
        add(0,1,KC  ,0, 0,0,0,0,20'h0,0);
        add(0,1,4'h9,0, 0,0,0,1,20'h9,0);
        add(0,1,KC  ,0, 0,0,0,0,20'h0,0);     // Clear from ENTRY
        add(0,1,4'h7,0, 0,0,0,1,20'h7,0);
        add(0,1,4'h4,0, 0,0,0,2,20'h74,0);
        add(1,1,4'h0,0, 0,0,0,0,20'h0,0);     // reset wins over key
        add(0,1,4'h3,0, 0,0,0,1,20'h3,0);
        add(0,1,4'h2,0, 0,0,0,2,20'h32,0);
        add(0,1,KE  ,0, 32,1,1,2,20'h32,0);
        add(0,1,KC  ,0, 0,0,0,0,20'h0,0);
        add(0,1,4'h0,0, 0,0,0,1,20'h0,0);     // leading zero counts
        add(0,1,4'h7,0, 0,0,0,2,20'h07,0);
        add(0,1,4'h4,0, 0,0,0,3,20'h074,0);
        add(0,1,4'h0,0, 0,0,0,4,20'h0740,0);
        add(0,1,4'h8,0, 0,0,0,5,20'h07408,0);
        add(0,1,KE  ,0, 7408,1,1,5,20'h07408,0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].kv, vecs[i].code, vecs[i].busy);
            chk_all($sformatf("vec%0d", i), vecs[i].ic, vecs[i].nv, vecs[i].st,
                    vecs[i].cnt, vecs[i].disp, vecs[i].ovf);
        end

        // Hand sequence: codes with key_valid low are not keypresses, and
        // ic_number holds while busy Enters are hammered in LOCKED.
        drive(0, 0, 4'h5, 0);
        chk_all("nokv0", 7408, 1, 0, 5, 20'h07408, 0);
        drive(0, 0, KC, 0);
        chk_all("nokv1", 7408, 1, 0, 5, 20'h07408, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, KE, 1);
            chk_all($sformatf("busy%0d", i), 7408, 1, 0, 5, 20'h07408, 0);
        end
        drive(0, 1, KE, 0);
        chk_all("rearm", 7408, 1, 1, 5, 20'h07408, 0);

        // Random phase against the reference model.
        drive(1, 0, 4'h0, 0);
        m_q.delete(); m_locked = 0; m_ic = 0; m_start = 0; m_ovf = 0;
        for (int i = 0; i < 3000; i++) begin
            logic       r, kv, busy;
            logic [3:0] code;
            int         p;
            r    = ($urandom_range(0, 199) == 0);
            kv   = ($urandom_range(0, 2) != 0);
            busy = ($urandom_range(0, 3) == 0);
            p    = $urandom_range(0, 9);
            if (p < 6)       code = 4'($urandom_range(0, 9));
            else if (p < 8)  code = KE;
            else if (p == 8) code = KC;
            else             code = 4'($urandom_range(0, 15));
            drive(r, kv, code, busy);
            model_step(r, kv, code, busy);
            chk_all($sformatf("rnd%0d", i), m_ic, m_locked, m_start,
                    4'(m_q.size()), model_disp(), m_ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
